cmp_sweep_checker: RTL and testbench
====================================

# cmp_sweep_checker

Self-checking stimulus engine for the magnitude-comparator interface. It drives the A/B operand side of a combinational comparator and sweeps every operand pair. For each pair it samples the three result flags, checks them against an internal golden model, and reports the error count, the first failing vector and a pass flag. It provides on-chip and at-bench exhaustive sign-off of comparator instances.

## Interface
Parameters:
- WIDTH, 4, operand width. The sweep covers 2^(2·WIDTH) pairs.
- SETTLE, 1, cycles each vector is held before the flags are sampled. Must be ≥ 1.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a sweep; honoured only in IDLE.
- A  out  WIDTH  operand A to the comparator under test.
- B  out  WIDTH  operand B to the comparator under test.
- A_gt_B  in  1  comparator flag, A > B.
- A_lt_B  in  1  comparator flag, A < B.
- A_eq_B  in  1  comparator flag, A == B.
- busy  out  1  sweep in progress.
- done  out  1  one-cycle pulse at the end of a sweep.
- pass  out  1  last completed sweep had zero errors; held until the next start.
- err_count  out  2·WIDTH+1  number of failing vectors in the current or last sweep.
- first_err_vld  out  1  first_err_a and first_err_b are valid.
- first_err_a  out  WIDTH  A value of the first failing vector.
- first_err_b  out  WIDTH  B value of the first failing vector.

## Operation
- The FSM has four states: IDLE → WAIT → CHECK → (WAIT | DONE) → IDLE.
- IDLE: when start=1, the block clears err_count, first_err_vld and pass, sets the vector index to 0 and goes to WAIT.
- Vector index: a 2·WIDTH-bit counter. A = idx[2W-1:W] and B = idx[W-1:0], so B is the inner loop. A and B are registered outputs.
- WAIT: the block holds the vector for SETTLE cycles, tracked by a settle counter, then goes to CHECK.
- CHECK: the block samples the flags and compares them with the expected flags {A>B, A<B, A==B}, computed unsigned.
  - Any mismatch in any of the three flags counts as exactly one error.
  - err_count increments on each error and saturates at its maximum value.
  - On the first error, the block captures A and B into first_err_a/first_err_b and sets first_err_vld.
  - If idx is all-ones, the next state is DONE. Otherwise idx increments and the next state is WAIT.
- DONE: done=1 for one cycle. pass is set to (err_count==0). The next state is IDLE.
- A start pulse outside IDLE is ignored. It is not queued.
- A and B hold their last value in IDLE and DONE.

## Timing
- Reset values: A=0, B=0, busy=0, done=0, pass=0, err_count=0, first_err_vld=0, first_err_a=0, first_err_b=0, FSM in IDLE.
- If start is sampled at edge 0:
  - busy=1 and A=B=0 from cycle 1.
  - Each vector takes SETTLE+1 cycles (SETTLE in WAIT, 1 in CHECK).
  - done=1 and busy=0 in cycle N·(SETTLE+1)+1, where N = 2^(2·WIDTH).
- Flags are sampled in CHECK against the A and B driven since that vector's first WAIT cycle.
- err_count and first_err_* update at the end of the CHECK cycle. They are visible in the following cycle.
- Reset mid-sweep: the sweep aborts and all outputs return to their reset values on the next edge. A subsequent start runs a full fresh sweep.
- start coincident with rst: rst wins.

## Configuration
- CMP_SWEEP_STOP_ON_ERR_EN
  - Defined: a CHECK that detects an error goes directly to DONE. err_count=1 and pass=0. A and B remain on the failing vector.
  - Undefined: the full sweep always completes and every failing vector is counted.

## Structure
- Package cmp_sweep_pkg contains:
  - the state enum (IDLE, WAIT, CHECK, DONE);
  - default WIDTH and SETTLE constants;
  - a function returning the expected {gt, lt, eq} triple for two operands.
- One sub-module, cmp_expect: the combinational golden model, which outputs expected flags from A and B. The FSM, counters and capture logic stay in the top.

## Test plan
- Correct comparator, WIDTH=4, SETTLE=1, start pulse → busy for 512 cycles, done at cycle 513, err_count=0, pass=1, first_err_vld=0.
- Comparator with A_eq_B stuck at 0 → err_count=16, pass=0, first_err_a=0, first_err_b=0.
- Comparator with A_gt_B stuck at 1 → err_count=136, first_err at A=0, B=0.
- CMP_SWEEP_STOP_ON_ERR_EN defined, A_eq_B stuck at 0 → done at cycle 3, err_count=1, A=0, B=0.
- start re-pulsed at cycle 50 of a sweep → ignored; done still at cycle 513.
- rst asserted at cycle 100 → next cycle busy=0, A=B=0, err_count=0; a new start then completes in 512 cycles with pass=1.

Source files
------------

// File: rtl/cmp_sweep_pkg.sv
// Shared types and the reference comparison for the comparator sweep checker.
// The stop-on-first-error behaviour (CMP_SWEEP_STOP_ON_ERR_EN) is selected in the top.
package cmp_sweep_pkg;

  localparam int unsigned DEF_WIDTH  = 4;
  localparam int unsigned DEF_SETTLE = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_e;

  typedef struct packed {
    logic gt;
    logic lt;
    logic eq;
  } flags_t;

  // Operands are passed zero-extended, so the comparison is unsigned.
  function automatic flags_t expect_flags(input logic [31:0] a, input logic [31:0] b);
    flags_t f;
    f.gt = (a > b);
    f.lt = (a < b);
    f.eq = (a == b);
    return f;
  endfunction

endpackage

// File: rtl/cmp_expect.sv
// Combinational golden model: expected {gt, lt, eq} flags for the current operands.
module cmp_expect
  import cmp_sweep_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output flags_t           exp_o
);

  assign exp_o = expect_flags(32'(a_i), 32'(b_i));

endmodule

// File: rtl/cmp_sweep_checker.sv
// Exhaustive operand sweep of an external magnitude comparator with error capture.
// Define CMP_SWEEP_STOP_ON_ERR_EN to end the sweep at the first failing vector.
module cmp_sweep_checker
  import cmp_sweep_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned SETTLE = DEF_SETTLE
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic [WIDTH-1:0]   A,
  output logic [WIDTH-1:0]   B,
  input  logic               A_gt_B,
  input  logic               A_lt_B,
  input  logic               A_eq_B,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [2*WIDTH:0]   err_count,
  output logic               first_err_vld,
  output logic [WIDTH-1:0]   first_err_a,
  output logic [WIDTH-1:0]   first_err_b
);

  localparam int unsigned IW = 2 * WIDTH;
  localparam int unsigned EW = 2 * WIDTH + 1;
  localparam int unsigned SW = (SETTLE < 2) ? 1 : $clog2(SETTLE);

`ifdef CMP_SWEEP_STOP_ON_ERR_EN
  localparam bit STOP_ON_ERR = 1'b1;
`else
  localparam bit STOP_ON_ERR = 1'b0;
`endif

  state_e            state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [SW-1:0]     settle_q, settle_d;
  logic [EW-1:0]     err_q, err_d;
  logic              vld_q, vld_d;
  logic [WIDTH-1:0]  fa_q, fa_d;
  logic [WIDTH-1:0]  fb_q, fb_d;
  logic              pass_q, pass_d;

  flags_t            exp_flags;
  flags_t            obs_flags;
  logic              mismatch;
  logic              last_vec;
  logic              settle_last;

  cmp_expect #(.WIDTH(WIDTH)) u_expect (
    .a_i   (A),
    .b_i   (B),
    .exp_o (exp_flags)
  );

  assign obs_flags   = '{gt: A_gt_B, lt: A_lt_B, eq: A_eq_B};
  assign mismatch    = (obs_flags != exp_flags);
  assign last_vec    = (idx_q == {IW{1'b1}});
  assign settle_last = (settle_q == SW'(SETTLE - 1));

  // NOTE: state and datapath registers use non-blocking assignments so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      settle_q <= '0;
      err_q    <= '0;
      vld_q    <= 1'b0;
      fa_q     <= '0;
      fb_q     <= '0;
      pass_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      settle_q <= settle_d;
      err_q    <= err_d;
      vld_q    <= vld_d;
      fa_q     <= fa_d;
      fb_q     <= fb_d;
      pass_q   <= pass_d;
    end
  end

  // NOTE: every combinational output is defaulted first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (start) state_d = WAIT;
      WAIT:  if (settle_last) state_d = CHECK;
      CHECK: if ((STOP_ON_ERR && mismatch) || last_vec) state_d = DONE;
             else state_d = WAIT;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    idx_d    = idx_q;
    settle_d = settle_q;
    err_d    = err_q;
    vld_d    = vld_q;
    fa_d     = fa_q;
    fb_d     = fb_q;
    pass_d   = pass_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          idx_d    = '0;
          settle_d = '0;
          err_d    = '0;
          vld_d    = 1'b0;
          pass_d   = 1'b0;
        end
      end
      WAIT: settle_d = settle_last ? '0 : settle_q + 1'b1;
      CHECK: begin
        if (mismatch) begin
          if (err_q != {EW{1'b1}}) err_d = err_q + 1'b1;
          if (!vld_q) begin
            vld_d = 1'b1;
            fa_d  = A;
            fb_d  = B;
          end
        end
        // The stop variant leaves A/B parked on the failing vector.
        if (!(STOP_ON_ERR && mismatch) && !last_vec) idx_d = idx_q + 1'b1;
        if (state_d == DONE) pass_d = (err_d == '0);
      end
      default: ;
    endcase
  end

  always_comb begin
    busy = (state_q == WAIT) || (state_q == CHECK);
    done = (state_q == DONE);
  end

  assign A             = idx_q[IW-1:WIDTH];
  assign B             = idx_q[WIDTH-1:0];
  assign pass          = pass_q;
  assign err_count     = err_q;
  assign first_err_vld = vld_q;
  assign first_err_a   = fa_q;
  assign first_err_b   = fb_q;

endmodule

// File: tb/tb_cmp_sweep_checker.sv
// Directed bench: runs full sweeps against a behavioural comparator with selectable faults.
module tb_cmp_sweep_checker;

  localparam int WIDTH  = 4;
  localparam int SETTLE = 1;
  localparam int BUDGET = 2000;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [WIDTH-1:0] A, B;
  logic             A_gt_B, A_lt_B, A_eq_B;
  logic             busy, done, pass, first_err_vld;
  logic [2*WIDTH:0] err_count;
  logic [WIDTH-1:0] first_err_a, first_err_b;

  int fault = 0;  // 0 correct, 1 eq stuck at 0, 2 gt stuck at 1
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cmp_sweep_checker #(.WIDTH(WIDTH), .SETTLE(SETTLE)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .A             (A),
    .B             (B),
    .A_gt_B        (A_gt_B),
    .A_lt_B        (A_lt_B),
    .A_eq_B        (A_eq_B),
    .busy          (busy),
    .done          (done),
    .pass          (pass),
    .err_count     (err_count),
    .first_err_vld (first_err_vld),
    .first_err_a   (first_err_a),
    .first_err_b   (first_err_b)
  );

  // Comparator under test, with injectable stuck-at faults.
  always_comb begin
    A_gt_B = (A > B);
    A_lt_B = (A < B);
    A_eq_B = (A == B);
    if (fault == 1) A_eq_B = 1'b0;
    if (fault == 2) A_gt_B = 1'b1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulses start, then follows the sweep until done; returns in the done cycle.
  task automatic run_sweep(input int fm, input int restart_at, output int done_cyc,
                           output int busy_cnt, output int ab_bad, output logic c1_pass);
    logic [7:0] kk;
    int cyc;
    fault    = fm;
    done_cyc = -1;
    busy_cnt = 0;
    ab_bad   = 0;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    cyc      = 1;
    c1_pass  = pass;
    while (cyc <= BUDGET) begin
      start = (cyc == restart_at);
      if (busy) begin
        busy_cnt++;
        kk = 8'((cyc - 1) / (SETTLE + 1));
        if (A !== kk[7:4] || B !== kk[3:0]) ab_bad++;
      end
      if (done) begin
        done_cyc = cyc;
        break;
      end
      tick();
      cyc++;
    end
    start = 1'b0;
  endtask

  typedef struct {
    int   fault;
    int   restart_at;
    int   exp_done;
    int   exp_err;
    bit   exp_pass;
    bit   exp_vld;
    int   exp_fa;
    int   exp_fb;
    int   exp_a;
    int   exp_b;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int   dc, bc, abb, rst_fault;
    logic p1;

`ifdef CMP_SWEEP_STOP_ON_ERR_EN
    vecs[0] = '{0, -1, 513,   0, 1'b1, 1'b0, 0, 0, 15, 15};
    vecs[1] = '{1, -1,   3,   1, 1'b0, 1'b1, 0, 0,  0,  0};
    vecs[2] = '{2, -1,   3,   1, 1'b0, 1'b1, 0, 0,  0,  0};
    vecs[3] = '{0, 50, 513,   0, 1'b1, 1'b0, 0, 0, 15, 15};
    rst_fault = 0;
`else
    vecs[0] = '{0, -1, 513,   0, 1'b1, 1'b0, 0, 0, 15, 15};
    vecs[1] = '{1, -1, 513,  16, 1'b0, 1'b1, 0, 0, 15, 15};
    vecs[2] = '{2, -1, 513, 136, 1'b0, 1'b1, 0, 0, 15, 15};
    vecs[3] = '{0, 50, 513,   0, 1'b1, 1'b0, 0, 0, 15, 15};
    rst_fault = 1;
`endif

    // Reset, with start held high alongside it: reset must win.
    start = 1'b1;
    repeat (3) tick();
    rst   = 1'b0;
    start = 1'b0;
    tick();
    check("rst_busy",  32'(busy), 0);
    check("rst_done",  32'(done), 0);
    check("rst_pass",  32'(pass), 0);
    check("rst_A",     32'(A), 0);
    check("rst_B",     32'(B), 0);
    check("rst_err",   32'(err_count), 0);
    check("rst_vld",   32'(first_err_vld), 0);
    check("rst_fa",    32'(first_err_a), 0);
    check("rst_fb",    32'(first_err_b), 0);

    for (int i = 0; i < 4; i++) begin
      run_sweep(vecs[i].fault, vecs[i].restart_at, dc, bc, abb, p1);
      check($sformatf("v%0d_done_cycle", i), 32'(dc), 32'(vecs[i].exp_done));
      check($sformatf("v%0d_busy_cycles", i), 32'(bc), 32'(vecs[i].exp_done - 1));
      check($sformatf("v%0d_ab_sequence_bad", i), 32'(abb), 0);
      check($sformatf("v%0d_pass_cleared", i), 32'(p1), 0);
      check($sformatf("v%0d_busy_in_done", i), 32'(busy), 0);
      check($sformatf("v%0d_err", i), 32'(err_count), 32'(vecs[i].exp_err));
      check($sformatf("v%0d_pass", i), 32'(pass), 32'(vecs[i].exp_pass));
      check($sformatf("v%0d_vld", i), 32'(first_err_vld), 32'(vecs[i].exp_vld));
      check($sformatf("v%0d_A_final", i), 32'(A), 32'(vecs[i].exp_a));
      check($sformatf("v%0d_B_final", i), 32'(B), 32'(vecs[i].exp_b));
      if (vecs[i].exp_vld) begin
        check($sformatf("v%0d_first_a", i), 32'(first_err_a), 32'(vecs[i].exp_fa));
        check($sformatf("v%0d_first_b", i), 32'(first_err_b), 32'(vecs[i].exp_fb));
      end
      tick();
      check($sformatf("v%0d_done_pulse", i), 32'(done), 0);
      check($sformatf("v%0d_pass_held", i), 32'(pass), 32'(vecs[i].exp_pass));
      check($sformatf("v%0d_A_held", i), 32'(A), 32'(vecs[i].exp_a));
      tick();
    end

    // Reset asserted during cycle 100 of a sweep.
    fault = rst_fault;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c < 100; c++) tick();
    check("mid_busy_before_rst", 32'(busy), 1);
`ifndef CMP_SWEEP_STOP_ON_ERR_EN
    check("mid_err_before_rst", 32'(err_count), 3);
`endif
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_A",    32'(A), 0);
    check("mid_rst_B",    32'(B), 0);
    check("mid_rst_err",  32'(err_count), 0);
    check("mid_rst_vld",  32'(first_err_vld), 0);
    tick();
    run_sweep(0, -1, dc, bc, abb, p1);
    check("after_rst_done_cycle", 32'(dc), 513);
    check("after_rst_busy_cycles", 32'(bc), 512);
    check("after_rst_ab_bad", 32'(abb), 0);
    check("after_rst_pass", 32'(pass), 1);
    check("after_rst_err", 32'(err_count), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
